// File: rtl/bsg_mul_iterative.sv
// bsg_mul_iterative: multi-cycle width_p x width_p -> 2*width_p integer multiplier
// retiring iter_step_p multiplier bits per cycle (N = width_p/iter_step_p cycles).
//
// Optional feature macro: BSG_MUL_ITERATIVE_SIGNED_EN
//   defined   : signed_i selects two's-complement operation (magnitude + negate).
//   undefined : signed_i is ignored and every operation is unsigned.
//
// Ports:
//   clk_i      in   clock, rising edge
//   reset_n_i  in   synchronous active-low reset
//   v_i        in   operand valid
//   ready_o    out  block can accept operands (registered)
//   x_i        in   multiplicand [width_p]
//   y_i        in   multiplier [width_p]
//   signed_i   in   1 = signed operation, sampled with operands
//   v_o        out  result valid (registered)
//   z_o        out  product [2*width_p] (registered)
//   yumi_i     in   consumer takes result; only meaningful while v_o = 1

module bsg_mul_iterative #(
    parameter int unsigned width_p     = 64,
    parameter int unsigned iter_step_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    output logic                   ready_o,
    input  logic [width_p-1:0]     x_i,
    input  logic [width_p-1:0]     y_i,
    input  logic                   signed_i,
    output logic                   v_o,
    output logic [2*width_p-1:0]   z_o,
    input  logic                   yumi_i
);

    localparam int unsigned W  = width_p;
    localparam int unsigned ZW = 2 * width_p;
    localparam int unsigned N  = width_p / iter_step_p;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_n;

    logic [ZW-1:0]   r_mcand;
    logic [W-1:0]    r_mplier;
    logic [ZW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [ZW-1:0]   r_z;
    logic            r_v;
    logic            r_ready;

    logic [W-1:0]    w_x_mag;
    logic [W-1:0]    w_y_mag;
    logic [ZW-1:0]   w_pp;
    logic [ZW-1:0]   w_acc_sum;
    logic [ZW-1:0]   w_result;
    logic            w_last;

    assign w_last = (r_cnt == CW'(1));

`ifdef BSG_MUL_ITERATIVE_SIGNED_EN
    logic            r_neg;
    logic            w_x_neg;
    logic            w_y_neg;

    // Magnitudes; -2^(W-1) maps to 2^(W-1) which still fits in W unsigned bits.
    assign w_x_neg  = signed_i & x_i[W-1];
    assign w_y_neg  = signed_i & y_i[W-1];
    assign w_x_mag  = w_x_neg ? (~x_i + W'(1)) : x_i;
    assign w_y_mag  = w_y_neg ? (~y_i + W'(1)) : y_i;
    assign w_result = r_neg ? (~w_acc_sum + ZW'(1)) : w_acc_sum;
`else
    logic            w_unused_signed;

    assign w_unused_signed = signed_i;
    assign w_x_mag         = x_i;
    assign w_y_mag         = y_i;
    assign w_result        = w_acc_sum;
`endif

    // Partial product: shifted multiplicand times the low iter_step_p multiplier bits.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < int'(iter_step_p); j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    assign w_acc_sum = r_acc + w_pp;

    // Next-state logic.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE: if (v_i)    w_state_n = S_CALC;
            S_CALC: if (w_last) w_state_n = S_DONE;
            S_DONE: if (yumi_i) w_state_n = S_IDLE;
            default:            w_state_n = S_IDLE;
        endcase
    end

    // State, handshake flags and datapath registers.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_v      <= 1'b0;
            r_z      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef BSG_MUL_ITERATIVE_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_n;
            r_ready <= (w_state_n == S_IDLE);
            r_v     <= (w_state_n == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (v_i) begin
                        r_mcand  <= ZW'(w_x_mag);
                        r_mplier <= w_y_mag;
                        r_acc    <= '0;
                        r_cnt    <= CW'(N);
`ifdef BSG_MUL_ITERATIVE_SIGNED_EN
                        r_neg    <= w_x_neg ^ w_y_neg;
`endif
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_sum;
                    r_mcand  <= r_mcand << iter_step_p;
                    r_mplier <= r_mplier >> iter_step_p;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_z <= w_result;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign v_o     = r_v;
    assign z_o     = r_z;

endmodule

// File: doc/bsg_mul_iterative.md
# bsg_mul_iterative

Parametrised, multi-cycle integer multiplier that computes a width_p × width_p → 2·width_p product, signed or unsigned per operation, retiring iter_step_p multiplier bits per cycle. It is the area-lean sibling of the fully combinational/pipelined 64-bit multiplier, for datapaths that can tolerate width_p/iter_step_p cycles of latency. Operands enter through a ready/valid handshake and the result leaves through a valid/yumi handshake, so the block drops directly into latency-insensitive pipelines.

## Interface
- width_p, 64, operand width; ≥ 2.
- iter_step_p, 1, multiplier bits retired per cycle; must divide width_p.
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_n_i  in  1  reset; synchronous and active-low.
- v_i  in  1  operand valid.
- ready_o  out  1  block can accept operands.
- x_i  in  width_p  multiplicand.
- y_i  in  width_p  multiplier.
- signed_i  in  1  1 = two's-complement operands and result, 0 = unsigned; sampled with operands.
- v_o  out  1  result valid.
- z_o  out  2·width_p  product.
- yumi_i  in  1  consumer takes result; legal only while v_o = 1.

## Operation
- N = width_p / iter_step_p iterations per product.
- States: IDLE → CALC → DONE → IDLE.
  - IDLE: ready_o = 1. On v_i & ready_o: latch operands and mode, clear accumulator, load counter with N, go to CALC.
  - CALC: each cycle, add (multiplicand × low iter_step_p bits of the multiplier) into the accumulator at the current offset, shift the multiplier right by iter_step_p, decrement the counter. On the cycle the counter reaches its last iteration, register the final (sign-corrected) product into z_o and go to DONE.
  - DONE: v_o = 1, z_o stable. On yumi_i go to IDLE.
- Signed mode: operands are converted to magnitudes (|−2^(width_p−1)| = 2^(width_p−1) as a width_p-bit unsigned value), the unsigned product is computed, and the result is negated if the operand signs differ. The full 2·width_p result is exact; no overflow is possible, including (−2^(w−1))².
- Unsigned mode: the straight unsigned product.
- Only one operation is in flight. No new operands are accepted in CALC or DONE.
- yumi_i without v_o is illegal. The design ignores it, and a bench assertion flags it.
- Reset (reset_n_i = 0 at an edge), in any state and including mid-CALC: state → IDLE, v_o = 0, z_o = 0, counter and accumulator cleared. The in-flight operation is discarded with no partial output.

## Timing
- Reset values: ready_o = 1 (in IDLE), v_o = 0, z_o = 0.
- Operands are accepted in cycle 0, CALC occupies cycles 1..N, and v_o = 1 from cycle N+1.
- Examples: width_p = 64, iter_step_p = 1 gives v_o at cycle 65. iter_step_p = 8 gives v_o at cycle 9.
- If yumi_i is high in cycle k, ready_o = 1 in cycle k+1. The minimum issue interval is N+2 cycles.
- ready_o, v_o and z_o come directly from registers. ready_o and v_o do not depend combinationally on v_i or yumi_i.
- x_i, y_i and signed_i are don't-care except in the accept cycle.

## Configuration
- BSG_MUL_ITERATIVE_SIGNED_EN defined: signed_i is honoured, and the magnitude-conversion and negation logic is built.
- Not defined: the logic is removed, signed_i is ignored, and every operation is unsigned. The port remains, so instantiations are unchanged.

## Test plan
- width_p = 8, iter_step_p = 2 (N = 4), unsigned: x = 0xFF, y = 0xFF → z_o = 0xFE01, v_o rises in cycle 5.
- Macro defined, signed: x = 0x80, y = 0x80 → 0x4000. x = 0xFD (−3), y = 0x05 → 0xFFF1. Same operands with signed_i = 0 → 0x04F1.
- Macro undefined: signed_i = 1 with x = 0xFD, y = 0x05 → 0x04F1.
- Backpressure: hold yumi_i = 0 for 10 cycles after v_o rises → z_o is stable, v_o stays 1, ready_o = 0 throughout, and v_i pulses are ignored. After yumi_i, ready_o = 1 in the next cycle.
- Reset mid-CALC: drive reset_n_i low in cycle 2 → next cycle v_o = 0, z_o = 0, ready_o = 1. A fresh 0x03 × 0x07 then gives 0x0015.
- width_p = 64, iter_step_p = 1 and 8: 1000 random back-to-back signed/unsigned operations with random yumi delay → every result matches a reference model, with latencies of 65 and 9 cycles respectively.
